dmem_arbiter: RTL and testbench

- Two-requester controller that shares the single-port 16-bit data memory between requester 0 (CPU load/store stage) and requester 1 (test/DMA port).
- After reset, it sequences a zero-fill of every memory word.
- It then arbitrates round-robin, registers the winning request, and drives the memory's address, write-data, write-enable and read-enable pins.
- Read data is captured and returned to the winner with a valid strobe.

---
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports, shared read return and the
// single-port data memory pins. slave = arbiter side, master = requesters + memory.
interface dmem_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              req0, we0, gnt0, rvalid0;
   logic [15:0]       addr0;
   logic [DATA_W-1:0] wdata0;
   logic              req1, we1, gnt1, rvalid1;
   logic [15:0]       addr1;
   logic [DATA_W-1:0] wdata1;
   logic [DATA_W-1:0] rdata;
   logic              err, busy;
   logic [15:0]       mem_access_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en, mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
      output gnt0, rvalid0, gnt1, rvalid1, rdata, err, busy,
             mem_access_addr, mem_write_data, mem_write_en, mem_read
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata, err, busy,
             mem_access_addr, mem_write_data, mem_write_en, mem_read
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two requesters,
// with an optional zero-fill sweep after reset.
module dmem_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 3,
   parameter int INIT_CLEAR = 1
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS} state_t;

   state_t                            state;
   logic [ADDR_W-1:0]                 init_ptr;
   logic                              last_winner;
   logic                              cmd_we, cmd_oor, cmd_id;
   logic [15:0]                       cmd_addr;
   logic [DATA_W-1:0]                 cmd_wdata;
   logic [DATA_W-1:0]                 rdata_q;
   logic [NUM_REQ-1:0]                rvalid_q;
   logic                              err_q;

   logic [NUM_REQ-1:0]                req, we, gnt;
   logic [NUM_REQ-1:0][15:0]          addr;
   logic [NUM_REQ-1:0][DATA_W-1:0]    wdata;
   logic                              win1;

   assign req   = {bus.req1, bus.req0};
   assign we    = {bus.we1, bus.we0};
   assign addr  = {bus.addr1, bus.addr0};
   assign wdata = {bus.wdata1, bus.wdata0};

   // Contention goes to whoever did not win last; last_winner resets to 1 so
   // the first contested grant lands on requester 0.
   assign win1 = req[1] && (!req[0] || !last_winner);
   assign gnt  = (state == S_IDLE && !rst) ? {win1, req[0] && !win1} : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= (INIT_CLEAR != 0) ? S_INIT : S_IDLE;
         init_ptr    <= '0;
         last_winner <= 1'b1;
         cmd_we      <= 1'b0;
         cmd_oor     <= 1'b0;
         cmd_id      <= 1'b0;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         rdata_q     <= '0;
         rvalid_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         rvalid_q <= '0;
         err_q    <= 1'b0;
         case (state)
            S_INIT: begin
               init_ptr <= init_ptr + 1'b1;
               if (init_ptr == {ADDR_W{1'b1}}) state <= S_IDLE;
            end
            S_IDLE: begin
               if (|gnt) begin
                  cmd_id      <= win1;
                  cmd_we      <= we[win1];
                  cmd_addr    <= addr[win1];
                  cmd_wdata   <= wdata[win1];
                  cmd_oor     <= |(addr[win1] >> ADDR_W);
                  last_winner <= win1;
                  state       <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cmd_oor) begin
                  err_q <= 1'b1;
               end else if (!cmd_we) begin
                  rdata_q          <= bus.mem_read_data;
                  rvalid_q[cmd_id] <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory pins decode straight from registered state; rst forces them idle so
   // an access cut short by reset never commits a write.
   logic [15:0]       m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_we, m_rd;

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_we    = 1'b0;
      m_rd    = 1'b0;
      if (!rst) begin
         case (state)
            S_INIT: begin
               m_addr = {{(16-ADDR_W){1'b0}}, init_ptr};
               m_we   = 1'b1;
            end
            S_ACCESS: begin
               if (!cmd_oor) begin
                  m_addr = cmd_addr;
                  if (cmd_we) begin
                     m_we    = 1'b1;
                     m_wdata = cmd_wdata;
                  end else begin
                     m_rd = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt0            = gnt[0];
   assign bus.gnt1            = gnt[1];
   assign bus.rvalid0         = rvalid_q[0];
   assign bus.rvalid1         = rvalid_q[1];
   assign bus.rdata           = rdata_q;
   assign bus.err             = err_q;
   assign bus.busy            = (state == S_INIT);
   assign bus.mem_access_addr = m_addr;
   assign bus.mem_write_data  = m_wdata;
   assign bus.mem_write_en    = m_we;
   assign bus.mem_read        = m_rd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, random traffic against a
// schedule-based reference model, reset-abort and no-clear sequences.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst0 = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if b ();
   dmem_arbiter_if b0 ();

   logic [15:0] pmem [8];
   assign b.mem_read_data = pmem[b.mem_access_addr[2:0]];
   always @(posedge clk) if (b.mem_write_en) pmem[b.mem_access_addr[2:0]] <= b.mem_write_data;
   assign b0.mem_read_data = 16'hA5A5;

   dmem_arbiter #(.DATA_W(16), .ADDR_W(3), .INIT_CLEAR(1)) u_dut (.clk(clk), .rst(rst), .bus(b));
   dmem_arbiter #(.DATA_W(16), .ADDR_W(3), .INIT_CLEAR(0)) u_dut_nc (.clk(clk), .rst(rst0), .bus(b0));

   typedef struct packed {
      logic rst, req0, we0; logic [15:0] addr0, wdata0;
      logic req1, we1;      logic [15:0] addr1, wdata1;
   } in_t;

   typedef struct packed {
      logic g0, g1, v0, v1, er, bz, we, rd;
      logic [15:0] a, d, rdt;
   } obs_t;

   typedef struct packed {
      in_t in;
      logic g0, g1, v0, v1, er, bz;
      logic [15:0] rd;
   } vec_t;

   int total = 0, bad = 0, cyc = 0;
   in_t cur = '0;

   // reference model: expected pin activity scheduled by absolute cycle number
   obs_t        sched [int];
   int          init_end = 0, free_at = 0;
   bit          last = 1'b1;
   logic [15:0] mmem [8];
   logic [15:0] rdm = '0;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_model();
      obs_t act, exp, t;
      bit w;
      logic [15:0] a, d;
      logic wr;
      act = '0;
      act.g0 = b.gnt0; act.g1 = b.gnt1; act.v0 = b.rvalid0; act.v1 = b.rvalid1;
      act.er = b.err; act.bz = b.busy; act.we = b.mem_write_en; act.rd = b.mem_read;
      act.a = b.mem_access_addr; act.d = b.mem_write_data; act.rdt = b.rdata;
      if (cur.rst) begin
         cmp("rst_idle_pins", {60'd0, act.g0, act.g1, act.we, act.rd}, 64'd0);
         sched.delete();
         init_end = cyc + 1 + 8;
         free_at  = init_end;
         last     = 1'b1;
         rdm      = '0;
         for (int i = 0; i < 8; i++) mmem[i] = '0;
      end else begin
         exp = sched.exists(cyc) ? sched[cyc] : '0;
         if (sched.exists(cyc)) sched.delete(cyc);
         if (exp.v0 || exp.v1) rdm = exp.rdt;
         exp.rdt = rdm;
         if (cyc < init_end) begin
            exp.bz = 1'b1; exp.we = 1'b1; exp.d = '0;
            exp.a  = 16'(cyc - (init_end - 8));
         end else if (cyc >= free_at && (cur.req0 || cur.req1)) begin
            w  = (cur.req0 && cur.req1) ? !last : cur.req1;
            if (w) exp.g1 = 1'b1; else exp.g0 = 1'b1;
            last    = w;
            free_at = cyc + 2;
            a  = w ? cur.addr1 : cur.addr0;
            d  = w ? cur.wdata1 : cur.wdata0;
            wr = w ? cur.we1 : cur.we0;
            if (a >= 16'd8) begin
               t = '0; t.er = 1'b1; sched[cyc+2] = t;
            end else if (wr) begin
               t = '0; t.we = 1'b1; t.a = a; t.d = d; sched[cyc+1] = t;
               mmem[a[2:0]] = d;
            end else begin
               t = '0; t.rd = 1'b1; t.a = a; sched[cyc+1] = t;
               t = '0; if (w) t.v1 = 1'b1; else t.v0 = 1'b1; t.rdt = mmem[a[2:0]];
               sched[cyc+2] = t;
            end
         end
         cmp("model", 64'(act), 64'(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst = cur.rst;
      b.req0 = cur.req0; b.we0 = cur.we0; b.addr0 = cur.addr0; b.wdata0 = cur.wdata0;
      b.req1 = cur.req1; b.we1 = cur.we1; b.addr1 = cur.addr1; b.wdata1 = cur.wdata1;
      @(negedge clk);
      check_model();
      cyc++;
   endtask

   vec_t tbl[$];
   logic [15:0] hold = '0;

   function automatic in_t mk_in(input logic q0, w0, input logic [15:0] a0, d0,
                                 input logic q1, w1, input logic [15:0] a1, d1);
      in_t i;
      i = '0;
      i.req0 = q0; i.we0 = w0; i.addr0 = a0; i.wdata0 = d0;
      i.req1 = q1; i.we1 = w1; i.addr1 = a1; i.wdata1 = d1;
      return i;
   endfunction

   function automatic void add(input in_t i, input logic g0, g1, v0, v1, er, bz,
                               input logic [15:0] rd);
      vec_t v;
      if (v0 || v1) hold = rd;
      v.in = i; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.er = er; v.bz = bz;
      v.rd = hold;
      tbl.push_back(v);
   endfunction

   function automatic logic [15:0] rnd_addr();
      if ($urandom % 8 == 0) return 16'($urandom_range(8, 16'hFFFF));
      return 16'($urandom % 8);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t idle;
      bit  g0_last, g1_last, got;
      idle = '0;
      b.req0 = 0; b.we0 = 0; b.addr0 = 0; b.wdata0 = 0;
      b.req1 = 0; b.we1 = 0; b.addr1 = 0; b.wdata1 = 0;
      b0.req0 = 1; b0.we0 = 0; b0.addr0 = 16'd4; b0.wdata0 = 0;
      b0.req1 = 0; b0.we1 = 0; b0.addr1 = 0; b0.wdata1 = 0;

      // directed table
      for (int k = 0; k < 8; k++) add(mk_in(1, 0, 3, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 0);
      add(mk_in(1, 0, 3, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 1, 0, 0, 0, 16'h0000);
      add(mk_in(1, 1, 5, 16'hBEEF, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(mk_in(0, 0, 0, 0, 1, 0, 5, 0), 0, 1, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 1, 0, 0, 16'hBEEF);
      for (int k = 0; k < 11; k++)
         add(mk_in(1, 0, 5, 0, 1, 0, 2, 0), k % 4 == 0, k % 4 == 2,
             k >= 2 && k % 4 == 2, k >= 4 && k % 4 == 0, 0, 0,
             (k % 4 == 2) ? 16'hBEEF : 16'h0000);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 1, 0, 0, 16'h0000);
      add(mk_in(0, 0, 0, 0, 1, 1, 16'h0009, 16'h1111), 0, 1, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(mk_in(1, 0, 1, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1, 0, 0);
      add(idle, 0, 0, 0, 0, 0, 0, 0);
      add(idle, 0, 0, 1, 0, 0, 0, 16'h0000);

      cur = '0; cur.rst = 1'b1;
      step(); step();
      foreach (tbl[i]) begin
         cur = tbl[i].in;
         step();
         cmp("vec_flags", {58'd0, b.gnt0, b.gnt1, b.rvalid0, b.rvalid1, b.err, b.busy},
             {58'd0, tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].er, tbl[i].bz});
         cmp("vec_rdata", 64'(b.rdata), 64'(tbl[i].rd));
      end

      // random traffic with protocol-respecting requesters
      cur = '0; g0_last = 0; g1_last = 0;
      for (int i = 0; i < 400; i++) begin
         if (!cur.req0 || g0_last) begin
            cur.req0 = ($urandom % 4) != 0; cur.we0 = $urandom % 2;
            cur.addr0 = rnd_addr(); cur.wdata0 = 16'($urandom);
         end
         if (!cur.req1 || g1_last) begin
            cur.req1 = ($urandom % 4) != 0; cur.we1 = $urandom % 2;
            cur.addr1 = rnd_addr(); cur.wdata1 = 16'($urandom);
         end
         cur.rst = ($urandom % 100) == 0;
         step();
         g0_last = b.gnt0; g1_last = b.gnt1;
      end

      // reset during the ACCESS cycle of a write
      cur = '0;
      for (int i = 0; i < 12; i++) step();
      cur = mk_in(1, 1, 2, 16'h1234, 0, 0, 0, 0);
      step();
      cmp("abort_gnt0", 64'(b.gnt0), 64'd1);
      cur = '0; cur.rst = 1'b1;
      step();
      cmp("abort_no_write", 64'(b.mem_write_en), 64'd0);
      cur = '0;
      step();
      cmp("abort_busy", 64'(b.busy), 64'd1);
      for (int i = 0; i < 7; i++) step();
      cur = mk_in(1, 0, 2, 0, 0, 0, 0, 0);
      got = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         step();
         got = b.gnt0;
      end
      cmp("abort_read_gnt", 64'(got), 64'd1);
      cur = '0;
      step(); step();
      cmp("abort_read_data", {47'd0, b.rvalid0, b.rdata}, {47'd0, 1'b1, 16'h0000});

      // no-clear instance: request pending across reset release
      @(posedge clk); #1 rst0 = 1'b0;
      @(negedge clk);
      cmp("nc_first_gnt", {62'd0, b0.gnt0, b0.busy}, {62'd0, 1'b1, 1'b0});
      @(posedge clk); #1 b0.req0 = 1'b0;
      @(negedge clk);
      cmp("nc_mem_read", {47'd0, b0.mem_read, b0.mem_access_addr}, {47'd0, 1'b1, 16'd4});
      @(posedge clk); #1;
      @(negedge clk);
      cmp("nc_rvalid", {46'd0, b0.rvalid0, b0.busy, b0.rdata}, {46'd0, 1'b1, 1'b0, 16'hA5A5});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
